result_writeback: RTL

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback_if.sv | 27 ++
 rtl/result_writeback.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/result_writeback_if.sv
// UB write-port bundle between the result writeback engine and the unified buffer.
// The master drives the strobe, address and row data. The slave returns the arbiter grant.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH (`ARRAY_SIZE * `DATA_WIDTH)
`endif

interface result_writeback_if;
    logic                     ub_wr_en;
    logic [`ADDR_WIDTH-1:0]   ub_wr_addr;
    logic [`BUFFER_WIDTH-1:0] ub_wr_data;
    logic                     ub_wr_ready;

    modport master (output ub_wr_en, output ub_wr_addr, output ub_wr_data, input ub_wr_ready);
    modport slave  (input ub_wr_en, input ub_wr_addr, input ub_wr_data, output ub_wr_ready);
endinterface

// File: rtl/result_writeback.sv
// Snapshots an NxN accumulator tile, requantizes it, and writes it row by row into the UB.
// Defining WB_SATURATE_EN clamps each narrowed element; otherwise the element wraps.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH (`ARRAY_SIZE * `DATA_WIDTH)
`endif

module result_writeback (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           wb_enable,
    input  logic [`ARRAY_SIZE*`ARRAY_SIZE*`ACC_WIDTH-1:0]  results_flat,
    input  logic                                           result_valid,
    input  logic [`ADDR_WIDTH-1:0]                         wb_base_addr,
    input  logic [4:0]                                     wb_shift,
    input  logic                                           wb_clear_err,
    result_writeback_if.master                             ub,
    output logic                                           wb_busy,
    output logic                                           wb_done,
    output logic                                           wb_overrun
);

    localparam int unsigned N     = `ARRAY_SIZE;
    localparam int unsigned DW    = `DATA_WIDTH;
    localparam int unsigned AW    = `ACC_WIDTH;
    localparam int unsigned ADW   = `ADDR_WIDTH;
    localparam int unsigned BW    = `BUFFER_WIDTH;
    localparam int unsigned RW    = N * N * AW;
    localparam int unsigned ROW_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t            state_q;
    logic [RW-1:0]     res_q;
    logic [ADW-1:0]    base_q;
    logic [4:0]        shift_q;
    logic [ROW_W-1:0]  row_q;
    logic              en_q;
    logic [ADW-1:0]    addr_q;
    logic [BW-1:0]     data_q;
    logic              busy_q;
    logic              done_q;
    logic              ovr_q;

    logic [ROW_W-1:0]  row_d;
    logic [BW-1:0]     cap_row_d;
    logic [BW-1:0]     next_row_d;
    logic              last_row;
    logic              overrun_set;

    // Rounding is done one bit wider than the accumulator, so the add never overflows.
    function automatic logic [DW-1:0] requant(input logic [AW-1:0] acc, input logic [4:0] sh);
        logic signed [AW:0] ext;
        logic signed [AW:0] rnd;
`ifdef WB_SATURATE_EN
        logic signed [AW:0] sat_max;
        logic signed [AW:0] sat_min;
`endif
        ext = {acc[AW-1], acc};
        rnd = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        ext = (ext + rnd) >>> sh;
`ifdef WB_SATURATE_EN
        sat_max = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
        sat_min = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};
        if (ext > sat_max) ext = sat_max;
        else if (ext < sat_min) ext = sat_min;
`endif
        return ext[DW-1:0];
    endfunction

    function automatic logic [BW-1:0] pack_row(input logic [RW-1:0] flat,
                                               input logic [ROW_W-1:0] r,
                                               input logic [4:0] sh);
        logic [BW-1:0] row;
        row = '0;
        for (int unsigned c = 0; c < N; c++) begin
            row[c*DW +: DW] = requant(flat[(32'(r) * N + c) * AW +: AW], sh);
        end
        return row;
    endfunction

    // The first row is requantized straight from the inputs so it is on the bus the cycle after capture.
    always_comb begin
        row_d       = row_q + ROW_W'(1);
        cap_row_d   = pack_row(results_flat, '0, wb_shift);
        next_row_d  = pack_row(res_q, row_d, shift_q);
        last_row    = (row_q == ROW_W'(N - 1));
        overrun_set = result_valid && wb_enable && (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            base_q  <= '0;
            shift_q <= '0;
            row_q   <= '0;
            en_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (overrun_set) ovr_q <= 1'b1;
            else if (wb_clear_err) ovr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (result_valid && wb_enable) begin
                        res_q   <= results_flat;
                        base_q  <= wb_base_addr;
                        shift_q <= wb_shift;
                        row_q   <= '0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        addr_q  <= wb_base_addr;
                        data_q  <= cap_row_d;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (en_q && ub.ub_wr_ready) begin
                        if (last_row) begin
                            row_q   <= '0;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q  <= row_d;
                            addr_q <= base_q + ADW'(row_d);
                            data_q <= next_row_d;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ub.ub_wr_en   = en_q;
    assign ub.ub_wr_addr = addr_q;
    assign ub.ub_wr_data = data_q;
    assign wb_busy       = busy_q;
    assign wb_done       = done_q;
    assign wb_overrun    = ovr_q;

endmodule
